memfifo_sim_gen: RTL and testbench
==================================

Name: memfifo_sim_gen

Overview:
- Simulated memory-FIFO source for Data Request testing.
- On a request it emulates DDR fetch latency, then streams a deterministic packet pattern as 64-bit words with first-word-fall-through semantics.
- Its outputs drive the simulated (B) inputs of the memory-data selector ahead of TOP_SERDES: B_SIM_DATA_READY, B_SIM_DATA_PCKTS, B_SIM_DATA.
- TOP_SERDES pops words with SIM_DATA_RE.

Parameters:
- LATENCY, 16, cycles from request acceptance to first word valid (DDR fetch emulation); legal range 1..65535.
- MAX_PCKTS, 1023, upper clamp on requested packet count.
- PATTERN, 16'hCAFE, constant placed in payload field DATA[31:16].

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- REQ_VALID  in  1  one-cycle data-request strobe
- REQ_EWTAG  in  16  event-window tag of request
- REQ_PCKTS  in  16  number of 128-bit packets requested
- SIM_DATA_RE  in  1  read enable from consumer; pops current word
- SIM_DATA_READY  out  1  current SIM_DATA word valid
- SIM_DATA_PCKTS  out  16  clamped packet count of active request
- SIM_DATA  out  64  current data word
- BUSY  out  1  request in progress; new requests ignored
- DONE  out  1  one-cycle pulse at end of request

Behaviour:
- Reset: clock CLK, reset RESET_N asynchronous active-low. All outputs 0; state IDLE; counters 0.
- Packet = 2 words; total words W = 2*P, where P = min(REQ_PCKTS, MAX_PCKTS). Packet counter is 16 bit; word-half bit is 1 bit.
- Word format:
  - DATA[63:48] = latched EWTAG
  - DATA[47:32] = packet index 0..P-1
  - DATA[31:16] = PATTERN
  - DATA[15:1] = 0
  - DATA[0] = half (0 = first word, 1 = second word)
- IDLE:
  - REQ_VALID=1 latches EWTAG and P, loads the latency counter with LATENCY, sets BUSY=1.
  - SIM_DATA_PCKTS = P from the next cycle until DONE.
  - If P==0: go to FINISH directly; READY never asserts.
  - Otherwise go to WAIT.
- WAIT: counter decrements each cycle. At 0, go to STREAM and set SIM_DATA_READY=1 with word 0 on SIM_DATA, i.e. LATENCY cycles after the request cycle.
- STREAM:
  - SIM_DATA_READY=1 continuously; SIM_DATA holds the current word until popped.
  - SIM_DATA_RE=1 advances to the next word in the following cycle, so back-to-back reads give one word per cycle.
  - On RE of the last word (index P-1, half 1): READY drops the next cycle and the FSM goes to FINISH.
- FINISH: DONE=1 for one cycle; BUSY, SIM_DATA_PCKTS and SIM_DATA cleared to 0; return to IDLE.
- REQ_VALID while BUSY: ignored, no effect on the current stream.
- REQ_VALID in the same cycle as DONE: ignored, because BUSY is still 1.
- SIM_DATA_RE while READY=0: ignored, no counter change.
- REQ_PCKTS > MAX_PCKTS: clamped; SIM_DATA_PCKTS reports the clamped value.
- RESET_N low mid-stream: immediate abort to IDLE with all outputs 0; no DONE pulse.

Optional Feature:
- Macro: SIM_GEN_LFSR_EN
- Defined:
  - DATA[31:16] carries a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - LFSR is seeded with the latched EWTAG at acceptance (0 replaced by 16'h0001).
  - It steps once per popped word.
- Undefined: DATA[31:16] = PATTERN and no LFSR logic is synthesized.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, WAIT, STREAM, FINISH)
  - word field offsets (EWTAG_MSB/LSB, PIDX_MSB/LSB, PAY_MSB/LSB)
  - WORDS_PER_PCKT=2
  - LFSR seed-zero substitute constant
- One sub-module: sim_lfsr16, with ports CLK, RESET_N, LOAD, SEED, STEP, Q; instantiated only under SIM_GEN_LFSR_EN.

Test Plan:
- LATENCY=16, REQ_EWTAG=16'h0012, REQ_PCKTS=3, RE held high -> READY rises exactly 16 cycles after REQ_VALID; words 0012_0000_CAFE_0000, 0012_0000_CAFE_0001 … 0012_0002_CAFE_0001 (6 words); DONE one cycle after the last pop; PCKTS=3 throughout.
- REQ_PCKTS=0 -> BUSY one cycle, READY never 1, DONE pulse, PCKTS returns to 0.
- REQ_PCKTS=2, RE toggled 1,0,1,0 -> SIM_DATA stable during RE=0 cycles; all 4 words delivered in order, none duplicated or skipped.
- Second REQ_VALID (EWTAG 16'h0099) mid-stream -> ignored; stream keeps EWTAG 16'h0012; DONE count = 1.
- REQ_PCKTS=16'hFFFF with MAX_PCKTS=1023 -> PCKTS=1023; 2046 words delivered; last word packet index 1022.
- RESET_N pulsed low after the 3rd word -> outputs 0 immediately, no DONE; a new request after release restarts at packet index 0. With SIM_GEN_LFSR_EN defined, EWTAG=16'h0001 -> DATA[31:16] sequence matches the reference LFSR model.

Source files
------------

// File: rtl/memfifo_sim_gen_pkg.sv
// Shared types and word layout for the simulated memory-FIFO source.
// Word = {EWTAG, packet index, payload, 15'b0, half}; two words per 128-bit packet.
package memfifo_sim_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int EWTAG_MSB = 63;
  localparam int EWTAG_LSB = 48;
  localparam int PIDX_MSB  = 47;
  localparam int PIDX_LSB  = 32;
  localparam int PAY_MSB   = 31;
  localparam int PAY_LSB   = 16;

  localparam int WORDS_PER_PCKT = 2;

  // An all-zero seed would lock the LFSR, so EWTAG 0 seeds with this instead.
  localparam logic [15:0] LFSR_SEED_ZERO = 16'h0001;

  function automatic logic [63:0] pack_word(
    input logic [15:0] ewtag,
    input logic [15:0] pidx,
    input logic [15:0] pay,
    input logic        half
  );
    logic [63:0] w;
    w = '0;
    w[EWTAG_MSB:EWTAG_LSB] = ewtag;
    w[PIDX_MSB:PIDX_LSB]   = pidx;
    w[PAY_MSB:PAY_LSB]     = pay;
    w[0]                   = half;
    return w;
  endfunction

endpackage

// File: rtl/memfifo_sim_gen_if.sv
// Request and first-word-fall-through data bus of the simulated memory-FIFO source.
// master = requester/consumer side, slave = generator side.
interface memfifo_sim_gen_if;

  logic        REQ_VALID;
  logic [15:0] REQ_EWTAG;
  logic [15:0] REQ_PCKTS;
  logic        SIM_DATA_RE;
  logic        SIM_DATA_READY;
  logic [15:0] SIM_DATA_PCKTS;
  logic [63:0] SIM_DATA;
  logic        BUSY;
  logic        DONE;

  modport master (
    output REQ_VALID, REQ_EWTAG, REQ_PCKTS, SIM_DATA_RE,
    input  SIM_DATA_READY, SIM_DATA_PCKTS, SIM_DATA, BUSY, DONE
  );

  modport slave (
    input  REQ_VALID, REQ_EWTAG, REQ_PCKTS, SIM_DATA_RE,
    output SIM_DATA_READY, SIM_DATA_PCKTS, SIM_DATA, BUSY, DONE
  );

endinterface

// File: rtl/memfifo_sim_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1; LOAD has priority over STEP.
// Latency: Q updates one cycle after LOAD/STEP; no backpressure.
module sim_lfsr16
  import memfifo_sim_gen_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        LOAD,
  input  logic [15:0] SEED,
  input  logic        STEP,
  output logic [15:0] Q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q <= LFSR_SEED_ZERO;
    end else if (LOAD) begin
      r_q <= SEED;
    end else if (STEP) begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/memfifo_sim_gen.sv
// Simulated memory-FIFO source: READY rises LATENCY cycles after the request edge, then FWFT words, one per SIM_DATA_RE.
// Payload is PATTERN, or an EWTAG-seeded LFSR when SIM_GEN_LFSR_EN is defined.
module memfifo_sim_gen
  import memfifo_sim_gen_pkg::*;
#(
  parameter int          LATENCY   = 16,
  parameter int          MAX_PCKTS = 1023,
  parameter logic [15:0] PATTERN   = 16'hCAFE
) (
  input logic              CLK,
  input logic              RESET_N,
  memfifo_sim_gen_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_ewtag;
  logic [15:0] w_ewtag_nxt;
  logic [15:0] r_pckts;
  logic [15:0] w_pckts_nxt;
  logic [15:0] r_lat_cnt;
  logic [15:0] w_lat_cnt_nxt;
  logic [15:0] r_pidx;
  logic [15:0] w_pidx_nxt;
  logic        r_half;
  logic        w_half_nxt;

  logic [15:0] w_req_p;
  logic        w_accept;
  logic        w_pop;
  logic        w_last;
  logic [15:0] w_pay;

  assign w_req_p  = (bus.REQ_PCKTS > 16'(MAX_PCKTS)) ? 16'(MAX_PCKTS) : bus.REQ_PCKTS;
  assign w_accept = (r_state == ST_IDLE) && bus.REQ_VALID;
  assign w_pop    = (r_state == ST_STREAM) && bus.SIM_DATA_RE;
  assign w_last   = (r_pidx == (r_pckts - 16'd1)) && (r_half == 1'(WORDS_PER_PCKT - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_ewtag   <= '0;
      r_pckts   <= '0;
      r_lat_cnt <= '0;
      r_pidx    <= '0;
      r_half    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ewtag   <= w_ewtag_nxt;
      r_pckts   <= w_pckts_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_pidx    <= w_pidx_nxt;
      r_half    <= w_half_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ewtag_nxt   = r_ewtag;
    w_pckts_nxt   = r_pckts;
    w_lat_cnt_nxt = r_lat_cnt;
    w_pidx_nxt    = r_pidx;
    w_half_nxt    = r_half;
    case (r_state)
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          w_ewtag_nxt   = bus.REQ_EWTAG;
          w_pckts_nxt   = w_req_p;
          w_lat_cnt_nxt = 16'(LATENCY);
          w_pidx_nxt    = '0;
          w_half_nxt    = 1'b0;
          w_state_nxt   = (w_req_p == 16'd0) ? ST_FINISH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leaving on count 1 lands READY exactly LATENCY edges after acceptance.
        if (r_lat_cnt <= 16'd1) begin
          w_lat_cnt_nxt = '0;
          w_state_nxt   = ST_STREAM;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 16'd1;
        end
      end
      ST_STREAM: begin
        if (w_pop) begin
          if (w_last) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_half_nxt = ~r_half;
            if (r_half) begin
              w_pidx_nxt = r_pidx + 16'd1;
            end
          end
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
        w_ewtag_nxt = '0;
        w_pckts_nxt = '0;
        w_pidx_nxt  = '0;
        w_half_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef SIM_GEN_LFSR_EN
  logic [15:0] w_seed;

  assign w_seed = (bus.REQ_EWTAG == 16'd0) ? LFSR_SEED_ZERO : bus.REQ_EWTAG;

  sim_lfsr16 u_lfsr (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .LOAD    (w_accept),
    .SEED    (w_seed),
    .STEP    (w_pop),
    .Q       (w_pay)
  );
`else
  logic w_unused_accept;

  assign w_unused_accept = w_accept;
  assign w_pay           = PATTERN;
`endif

  assign bus.SIM_DATA_READY = (r_state == ST_STREAM);
  assign bus.BUSY           = (r_state != ST_IDLE);
  assign bus.DONE           = (r_state == ST_FINISH);
  assign bus.SIM_DATA_PCKTS = r_pckts;
  assign bus.SIM_DATA       = (r_state == ST_STREAM) ? pack_word(r_ewtag, r_pidx, w_pay, r_half)
                                                     : 64'd0;

endmodule

// File: tb/tb_memfifo_sim_gen.sv
// Directed + randomized bench for memfifo_sim_gen against a queue-based word model.
module tb_memfifo_sim_gen;

  logic CLK;
  logic RESET_N;
  int   checks;
  int   errors;
  int   done_cnt;

  memfifo_sim_gen_if bus ();

  memfifo_sim_gen #(
    .LATENCY   (16),
    .MAX_PCKTS (1023),
    .PATTERN   (16'hCAFE)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (bus.DONE === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode: 0 = RE held high, 1 = RE toggles 1,0,1,0, 2 = random RE
  task automatic run_req(input logic [15:0] ewtag, input logic [15:0] req_p, input int mode,
                         input int inject_at, input int abort_at, input bit req_at_done);
    logic [63:0] exp_q[$];
    logic [15:0] p;
    logic [15:0] pay;
    int          w;
    int          lat;
    int          idx;
    int          cyc;
    int          done0;
    bit          re;
`ifdef SIM_GEN_LFSR_EN
    logic [15:0] lf;
    lf = (ewtag == 16'd0) ? 16'h0001 : ewtag;
`endif
    p = (req_p > 16'd1023) ? 16'd1023 : req_p;
    w = 2 * int'(p);
    for (int i = 0; i < int'(p); i++) begin
      for (int h = 0; h < 2; h++) begin
`ifdef SIM_GEN_LFSR_EN
        pay = lf;
        lf  = lfsr_next(lf);
`else
        pay = 16'hCAFE;
`endif
        exp_q.push_back({ewtag, 16'(i), pay, 15'd0, 1'(h)});
      end
    end
    done0 = done_cnt;

    bus.REQ_EWTAG = ewtag;
    bus.REQ_PCKTS = req_p;
    bus.REQ_VALID = 1'b1;
    tick();
    bus.REQ_VALID = 1'b0;
    chk("busy_after_req", 64'(bus.BUSY), 64'd1);
    chk("pckts_clamped", 64'(bus.SIM_DATA_PCKTS), 64'(p));

    if (p == 16'd0) begin
      chk("zero_done", 64'(bus.DONE), 64'd1);
      chk("zero_ready", 64'(bus.SIM_DATA_READY), 64'd0);
      tick();
      chk("zero_busy_clr", 64'(bus.BUSY), 64'd0);
      chk("zero_pckts_clr", 64'(bus.SIM_DATA_PCKTS), 64'd0);
      chk("zero_done_cnt", 64'(done_cnt - done0), 64'd1);
      return;
    end

    lat = 0;
    while (bus.SIM_DATA_READY !== 1'b1 && lat < 200) begin
      bus.SIM_DATA_RE = (mode == 0) ? 1'b1 : 1'($urandom);
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'd16);
    if (lat != 16) begin
      bus.SIM_DATA_RE = 1'b0;
      return;
    end

    idx = 0;
    cyc = 0;
    while (idx < w && cyc < 4 * w + 50) begin
      if (abort_at >= 0 && idx == abort_at) begin
        bus.SIM_DATA_RE = 1'b0;
        RESET_N = 1'b0;
        #1;
        chk("abort_ready", 64'(bus.SIM_DATA_READY), 64'd0);
        chk("abort_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_data", bus.SIM_DATA, 64'd0);
        chk("abort_pckts", 64'(bus.SIM_DATA_PCKTS), 64'd0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        chk("abort_no_done", 64'(done_cnt - done0), 64'd0);
        return;
      end
      chk("stream_ready", 64'(bus.SIM_DATA_READY), 64'd1);
      chk("stream_word", bus.SIM_DATA, exp_q[idx]);
      chk("stream_pckts", 64'(bus.SIM_DATA_PCKTS), 64'(p));
      case (mode)
        0:       re = 1'b1;
        1:       re = (cyc % 2 == 0);
        default: re = 1'($urandom);
      endcase
      bus.SIM_DATA_RE = re;
      if (inject_at >= 0 && idx == inject_at) begin
        bus.REQ_EWTAG = 16'h0099;
        bus.REQ_PCKTS = 16'd7;
        bus.REQ_VALID = 1'b1;
      end
      tick();
      bus.REQ_VALID = 1'b0;
      if (re) idx++;
      cyc++;
    end
    bus.SIM_DATA_RE = 1'b0;
    chk("all_words_popped", 64'(idx), 64'(w));

    chk("finish_done", 64'(bus.DONE), 64'd1);
    chk("finish_ready", 64'(bus.SIM_DATA_READY), 64'd0);
    chk("finish_data", bus.SIM_DATA, 64'd0);
    if (req_at_done) begin
      bus.REQ_EWTAG = 16'h0055;
      bus.REQ_PCKTS = 16'd1;
      bus.REQ_VALID = 1'b1;
    end
    tick();
    bus.REQ_VALID = 1'b0;
    chk("idle_busy", 64'(bus.BUSY), 64'd0);
    chk("idle_done", 64'(bus.DONE), 64'd0);
    chk("idle_pckts", 64'(bus.SIM_DATA_PCKTS), 64'd0);
    chk("done_count", 64'(done_cnt - done0), 64'd1);
    tick();
    chk("idle_stays", 64'(bus.BUSY), 64'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    done_cnt        = 0;
    RESET_N         = 1'b0;
    bus.REQ_VALID   = 1'b0;
    bus.REQ_EWTAG   = '0;
    bus.REQ_PCKTS   = '0;
    bus.SIM_DATA_RE = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(bus.SIM_DATA_READY), 64'd0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    chk("rst_pckts", 64'(bus.SIM_DATA_PCKTS), 64'd0);
    chk("rst_data", bus.SIM_DATA, 64'd0);
    RESET_N = 1'b1;
    tick();

    // bus.SIM_DATA_RE pulsed while idle must not matter
    bus.SIM_DATA_RE = 1'b1;
    tick();
    bus.SIM_DATA_RE = 1'b0;

    run_req(16'h0012, 16'd3, 0, -1, -1, 1'b0);
    run_req(16'h0abc, 16'd0, 0, -1, -1, 1'b0);
    run_req(16'h0034, 16'd2, 1, -1, -1, 1'b0);
    run_req(16'h0012, 16'd4, 0, 2, -1, 1'b0);
    run_req(16'h0012, 16'd2, 0, -1, -1, 1'b1);
    run_req(16'habcd, 16'hffff, 0, -1, -1, 1'b0);
    run_req(16'h0012, 16'd5, 0, -1, 3, 1'b0);
    run_req(16'h0012, 16'd3, 2, -1, -1, 1'b0);
    run_req(16'h0001, 16'd4, 0, -1, -1, 1'b0);
    run_req(16'h0000, 16'd3, 2, -1, -1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_req(16'($urandom), 16'($urandom_range(0, 6)), 2, -1, -1, 1'(r % 2));
    end
    run_req(16'h7777, 16'd1024, 2, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
